// File: rtl/lane_scheduler.sv
// Round-robin scheduler feeding one clk8f serial datapath from four lanes, plus clock-domain strobes.
// Define LANE_SCHED_RR_EN for round-robin arbitration; leave it undefined for fixed priority (lane 0 highest).
module lane_scheduler #(
  parameter int         DATA_WIDTH  = 8,
  parameter logic [7:0] IDLE_WORD   = 8'hBC,
  parameter int         SYNC_CYCLES = 8
) (
  input  logic                  clk8f,
  input  logic                  reset,
  input  logic [3:0]            valid_in,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  output logic [3:0]            ready_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [1:0]            lane_out,
  output logic                  sync_done,
  output logic [2:0]            phase,
  output logic                  clk4f_en,
  output logic                  clk2f_en,
  output logic                  clkf_en
);

  localparam logic [DATA_WIDTH-1:0] IdleWord = DATA_WIDTH'(IDLE_WORD);
  localparam logic [7:0]            SyncLast = 8'(SYNC_CYCLES - 1);

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              syncCnt_q, syncCnt_d;
  logic [3:0]              grant;
  logic [1:0]              grantIdx;
  logic                    grantFound;
  logic [1:0]              cand;
  logic                    transfer;
  logic [DATA_WIDTH-1:0]   selData;
  logic [DATA_WIDTH-1:0]   dataOut_q, dataOut_d;
  logic                    validOut_q, validOut_d;
  logic [1:0]              laneOut_q, laneOut_d;
  logic                    syncDone_q;
  logic [2:0]              phase_q, phase_d;
  logic                    clk4fEn_q, clk2fEn_q, clkfEn_q;

`ifdef LANE_SCHED_RR_EN
  logic [1:0]              lastGrant_q, lastGrant_d;
`endif

  always_ff @(posedge clk8f or posedge reset) begin
    if (reset) begin
      state_q   <= SYNC;
      syncCnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      syncCnt_q <= syncCnt_d;
    end
  end

  // The preamble holds the idle word for SYNC_CYCLES edges, then arbitration runs until the next reset.
  always_comb begin
    state_d   = state_q;
    syncCnt_d = syncCnt_q;
    if (state_q == SYNC) begin
      if (syncCnt_q == SyncLast) begin
        state_d = ACTIVE;
      end else begin
        syncCnt_d = syncCnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    grant      = 4'b0000;
    grantIdx   = 2'd0;
    grantFound = 1'b0;
    cand       = 2'd0;
    if (state_q == ACTIVE) begin
`ifdef LANE_SCHED_RR_EN
      for (int k = 1; k <= 4; k++) begin
        cand = lastGrant_q + 2'(k);
        if (!grantFound && valid_in[cand]) begin
          grantFound = 1'b1;
          grantIdx   = cand;
        end
      end
`else
      for (int k = 0; k < 4; k++) begin
        cand = 2'(k);
        if (!grantFound && valid_in[cand]) begin
          grantFound = 1'b1;
          grantIdx   = cand;
        end
      end
`endif
      if (grantFound) begin
        grant[grantIdx] = 1'b1;
      end
    end
  end

  assign ready_out = grant;
  assign transfer  = grantFound;

  always_comb begin
    selData = data_in0;
    case (grantIdx)
      2'd0:    selData = data_in0;
      2'd1:    selData = data_in1;
      2'd2:    selData = data_in2;
      default: selData = data_in3;
    endcase
  end

  always_comb begin
    dataOut_d  = IdleWord;
    validOut_d = 1'b0;
    laneOut_d  = 2'd0;
    if (transfer) begin
      dataOut_d  = selData;
      validOut_d = 1'b1;
      laneOut_d  = grantIdx;
    end
  end

`ifdef LANE_SCHED_RR_EN
  // Pointer only moves on an accepted word, so idle cycles keep the rotation fair.
  assign lastGrant_d = transfer ? grantIdx : lastGrant_q;

  always_ff @(posedge clk8f or posedge reset) begin
    if (reset) begin
      lastGrant_q <= 2'd3;
    end else begin
      lastGrant_q <= lastGrant_d;
    end
  end
`endif

  always_ff @(posedge clk8f or posedge reset) begin
    if (reset) begin
      dataOut_q  <= IdleWord;
      validOut_q <= 1'b0;
      laneOut_q  <= 2'd0;
      syncDone_q <= 1'b0;
    end else begin
      dataOut_q  <= dataOut_d;
      validOut_q <= validOut_d;
      laneOut_q  <= laneOut_d;
      syncDone_q <= (state_d == ACTIVE);
    end
  end

  // Strobes are derived from the next phase so they line up with the phase value registered beside them.
  assign phase_d = phase_q + 3'd1;

  always_ff @(posedge clk8f or posedge reset) begin
    if (reset) begin
      phase_q   <= 3'd0;
      clk4fEn_q <= 1'b0;
      clk2fEn_q <= 1'b0;
      clkfEn_q  <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      clk4fEn_q <= phase_d[0];
      clk2fEn_q <= &phase_d[1:0];
      clkfEn_q  <= &phase_d;
    end
  end

  assign data_out  = dataOut_q;
  assign valid_out = validOut_q;
  assign lane_out  = laneOut_q;
  assign sync_done = syncDone_q;
  assign phase     = phase_q;
  assign clk4f_en  = clk4fEn_q;
  assign clk2f_en  = clk2fEn_q;
  assign clkf_en   = clkfEn_q;

  grantOneHot: assert property (@(posedge clk8f) disable iff (reset) $onehot0(ready_out));
  grantOnlyValid: assert property (@(posedge clk8f) disable iff (reset) (ready_out & ~valid_in) == 4'b0000);

endmodule

// File: doc/lane_scheduler.md
# lane_scheduler

Round-robin scheduler sharing the single clk8f-rate serial datapath between four lane requesters. Each cycle it grants one requesting lane and forwards that lane's word to the output register, or inserts an idle word when no lane requests. It also generates the phase-aligned enable strobes that sequence the clkf/clk2f/clk4f domains of the clock generator. After reset it runs a fixed synchronisation preamble of idle words, then starts arbitration.

## Interface
- DATA_WIDTH, 8, width of each lane word and of data_out
- IDLE_WORD, 8'hBC, word driven on data_out when no grant; truncated to DATA_WIDTH
- SYNC_CYCLES, 8, number of idle cycles emitted after reset before arbitration starts (1–255)

- clk8f  in  1  fastest clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- valid_in  in  4  lane i requests when valid_in[i]=1
- data_in0..data_in3  in  DATA_WIDTH each  lane words, sampled on grant
- ready_out  out  4  one-hot combinational grant; a transfer occurs for lane i when valid_in[i] & ready_out[i] are high at a clk8f edge
- data_out  out  DATA_WIDTH  registered forwarded word, or IDLE_WORD
- valid_out  out  1  registered; 1 when data_out carries a lane word
- lane_out  out  2  registered index of the lane carried by data_out; 0 when valid_out=0
- sync_done  out  1  registered; 1 once the FSM is in ACTIVE
- phase  out  3  registered free-running cycle counter
- clk4f_en, clk2f_en, clkf_en  out  1 each  registered domain strobes

## Operation
- FSM states: SYNC, ACTIVE. Reset enters SYNC with sync count 0.
- SYNC: ready_out=0; data_out=IDLE_WORD, valid_out=0. The sync counter increments each cycle. When the count reaches SYNC_CYCLES-1, the FSM moves to ACTIVE on the next edge. Requests during SYNC are held off, never dropped.
- ACTIVE: arbitration every cycle. The search starts at lane (last_grant+1) mod 4 and grants the first lane with valid_in set. last_grant resets to 3, so lane 0 has first priority. last_grant updates only on a transfer.
- No valid_in in ACTIVE: ready_out=0. On the next edge data_out=IDLE_WORD, valid_out=0, lane_out=0.
- ready_out depends only on valid_in, FSM state and last_grant. It is never asserted for a lane whose valid_in is low.
- Phase counter runs in both states and wraps 7→0.
  - clk4f_en=1 when phase[0]=1.
  - clk2f_en=1 when phase[1:0]=3.
  - clkf_en=1 when phase=7.
  - Strobes are registered together with phase, so they align with the phase value shown.
- Asserting reset mid-operation aborts any in-flight word. Outputs return to reset values asynchronously, and the FSM re-runs the full SYNC preamble.
- FSM leaves ACTIVE only on reset.

## Timing
- Reset values: data_out=IDLE_WORD, valid_out=0, lane_out=0, ready_out=0, sync_done=0, phase=0, all strobes=0.
- Grant to output latency is 1 cycle. A word accepted at edge n appears on data_out/valid_out/lane_out after edge n.
- Throughput is one word per clk8f cycle. With k lanes requesting continuously, each lane is served once every k cycles.
- sync_done rises on the same edge that the first ACTIVE-state arbitration becomes possible. The first grant may occur in the cycle after sync_done rises.
- Reset deassertion is assumed synchronous to clk8f at system level. The first counting edge is the first rising edge with reset low.

## Configuration
- LANE_SCHED_RR_EN
  - Defined: round-robin arbitration as described above.
  - Undefined: fixed priority, lane 0 highest, lane 3 lowest. last_grant is removed; all other behaviour and timing are unchanged.

## Test plan
- Reset, then release with valid_in=4'b1111 → ready_out=0 and data_out=8'hBC for 8 cycles; sync_done=1 after the 8th edge; first grant goes to lane 0; data_out order 0,1,2,3,0…
- ACTIVE, valid_in=4'b1010, data_in1=8'h11, data_in3=8'h33 → data_out alternates 11,33,11,33 with lane_out 1,3,1,3 and valid_out=1.
- ACTIVE, valid_in=0 for 3 cycles → data_out=8'hBC, valid_out=0, lane_out=0, ready_out=0 each cycle.
- Free run for 16 cycles → phase 0..7,0..7; clk4f_en on odd phases; clk2f_en at phases 3 and 7; clkf_en only at phase 7.
- Reset pulse mid-stream while data_out=8'h33 → outputs immediately go to reset values; 8 idle cycles follow before the next grant.
- Without LANE_SCHED_RR_EN, valid_in=4'b1111 → lane 0 is granted every cycle; lanes 1–3 get ready_out=0.
